// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets one of four requesters at a time
// write a whole packet (1..16 words) into a shared downstream FIFO.
// A packet is granted only if the FIFO has room for all of its words. A
// blocked head requester is retried every cycle and never skipped, so a
// smaller packet cannot overtake it. Each packet is followed by GAP_CYCLES
// idle cycles so the FIFO occupancy count can settle.
//
// Ports:
//   clk             - clock
//   rst             - synchronous active-high reset
//   i_req[3:0]      - per-requester packet request, held until the last ack
//   i_len[15:0]     - 4 bits per requester, packet length minus one
//   i_data[255:0]   - 64 bits per requester, current word of that requester
//   o_ack[3:0]      - per-requester word pop, high when a word is written
//   o_gnt[3:0]      - one-hot registered owner of the FIFO write port
//   o_fifo_wr_data  - FIFO write data
//   o_fifo_wr_en    - FIFO write enable
//   i_fifo_full     - FIFO full flag (stalls the transfer)
//   i_fifo_wr_words - FIFO write-side occupancy
//   o_busy          - high whenever the arbiter is not idle
module fifo_wr_arb #(
  parameter int FIFO_DEPTH = 512,
  parameter int GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   i_req,
  input  logic [15:0]  i_len,
  input  logic [255:0] i_data,
  output logic [3:0]   o_ack,
  output logic [3:0]   o_gnt,
  output logic [63:0]  o_fifo_wr_data,
  output logic         o_fifo_wr_en,
  input  logic         i_fifo_full,
  input  logic [9:0]   i_fifo_wr_words,
  output logic         o_busy
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Gap counter counts down to zero, so it is loaded with one less than the
  // gap length.
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [10:0]   DEPTH    = 11'(FIFO_DEPTH);

  state_t        state_reg, state_next;
  logic [1:0]    rr_ptr_reg, rr_ptr_next;
  logic [1:0]    owner_reg, owner_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [3:0]    gnt_reg, gnt_next;
  logic [GW-1:0] gap_reg, gap_next;

  logic [3:0]    len_arr  [4];
  logic [63:0]   data_arr [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign len_arr[gi]  = i_len[4*gi +: 4];
      assign data_arr[gi] = i_data[64*gi +: 64];
    end
  endgenerate

  // First requester at or after rr_ptr (wrapping). Offsets are scanned from
  // the far end so the closest one is the last assignment and wins.
  logic [1:0] sel;
  logic       sel_valid;
  logic [1:0] idx;
  always_comb begin
    sel       = rr_ptr_reg;
    sel_valid = 1'b0;
    idx       = rr_ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr_reg + 2'(k);
      if (i_req[idx]) begin
        sel       = idx;
        sel_valid = 1'b1;
      end
    end
  end

  // 11 bits hold 1023 + 16 without overflow.
  logic space_ok;
  assign space_ok = ({1'b0, i_fifo_wr_words} + 11'(len_arr[sel]) + 11'd1) <= DEPTH;

  // Write strobe is gated by rst so nothing is popped during a reset cycle.
  logic wr;
  assign wr = (state_reg == XFER) && !i_fifo_full && !rst;

  assign o_fifo_wr_en   = wr;
  assign o_ack          = wr ? (4'b0001 << owner_reg) : 4'b0000;
  assign o_fifo_wr_data = (state_reg == XFER) ? data_arr[owner_reg] : 64'd0;
  assign o_gnt          = gnt_reg;
  assign o_busy         = (state_reg != IDLE);

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    gnt_next    = gnt_reg;
    gap_next    = gap_reg;
    case (state_reg)
      IDLE: begin
        if (sel_valid && space_ok) begin
          state_next = XFER;
          owner_next = sel;
          cnt_next   = len_arr[sel];
          gnt_next   = 4'b0001 << sel;
        end
      end
      XFER: begin
        if (wr) begin
          if (cnt_reg == 4'd0) begin
            gnt_next    = 4'b0000;
            rr_ptr_next = owner_reg + 2'd1;
            gap_next    = GAP_LOAD;
            state_next  = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_reg == '0) state_next = IDLE;
        else               gap_next   = gap_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 2'd0;
      owner_reg  <= 2'd0;
      cnt_reg    <= 4'd0;
      gnt_reg    <= 4'd0;
      gap_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
      cnt_reg    <= cnt_next;
      gnt_reg    <= gnt_next;
      gap_reg    <= gap_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: a constant vector table for the basic packet
// sequence, hand-written corner sequences and a randomized run, all checked
// against a packet-level reference model.
module tb_fifo_wr_arb;
  localparam int GAP   = 2;
  localparam int DEPTH = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   i_req;
  logic [15:0]  i_len;
  logic [255:0] i_data;
  logic [3:0]   o_ack;
  logic [3:0]   o_gnt;
  logic [63:0]  o_fifo_wr_data;
  logic         o_fifo_wr_en;
  logic         i_fifo_full;
  logic [9:0]   i_fifo_wr_words;
  logic         o_busy;

  always #5 clk = ~clk;

  fifo_wr_arb #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_len(i_len), .i_data(i_data),
    .o_ack(o_ack), .o_gnt(o_gnt), .o_fifo_wr_data(o_fifo_wr_data),
    .o_fifo_wr_en(o_fifo_wr_en), .i_fifo_full(i_fifo_full),
    .i_fifo_wr_words(i_fifo_wr_words), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: owner of the current packet (-1 = none), words still to
  // be written, idle gap cycles remaining, and round-robin start point.
  int m_owner, m_left, m_gap, m_ptr;
  int wi [4];    // word index inside current packet of each requester
  int pkt [4];   // packet id of each requester
  int plen [4];  // length field of the granted packet
  int obs [4];   // acks seen from the DUT for the current packet
  bit done [4];
  bit auto_drop;
  int dq [$];    // requester index at each rising edge of DUT o_gnt
  logic [3:0] prev_gnt;
  int prev_words, rise_words;

  function automatic logic [63:0] word_of(int r);
    return {8'(r), 24'(pkt[r]), 32'(wi[r])};
  endfunction

  task automatic drive_data();
    for (int r = 0; r < 4; r++) i_data[64*r +: 64] = word_of(r);
  endtask

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_gap = 0; m_ptr = 0;
    for (int r = 0; r < 4; r++) begin
      wi[r] = 0; obs[r] = 0; done[r] = 0;
    end
  endtask

  task automatic raw_reset();
    rst = 1'b1;
    drive_data();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    prev_gnt = 4'd0;
  endtask

  task automatic run_cycle();
    logic [3:0] eg, ea;
    logic       ee, eb;
    bit         found;
    int         o, r, l;
    drive_data();
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    ee = (m_owner >= 0) && !i_fifo_full && !rst;
    ea = ee ? eg : 4'd0;
    eb = (m_owner >= 0) || (m_gap > 0);
    check("gnt", o_gnt, eg);
    check("wr_en", o_fifo_wr_en, ee);
    check("ack", o_ack, ea);
    check("busy", o_busy, eb);
    if (ee) check("wr_data", o_fifo_wr_data, word_of(m_owner));
    for (int k = 0; k < 4; k++) if (o_ack[k] === 1'b1) obs[k]++;
    if (o_gnt != 4'd0 && prev_gnt == 4'd0) begin
      for (int k = 0; k < 4; k++) if (o_gnt[k]) dq.push_back(k);
      rise_words = prev_words;
    end
    prev_gnt   = o_gnt;
    prev_words = int'(i_fifo_wr_words);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (ee) begin
        o = m_owner;
        wi[o]++;
        m_left--;
        if (m_left == 0) begin
          check("pkt_words", 64'(obs[o]), 64'(plen[o] + 1));
          done[o] = 1; pkt[o]++; wi[o] = 0;
          m_ptr = (o + 1) % 4; m_owner = -1; m_gap = GAP;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        r = (m_ptr + k) % 4;
        if (!found && i_req[r]) begin
          found = 1;
          l = int'(i_len[4*r +: 4]);
          if (int'(i_fifo_wr_words) + l + 1 <= DEPTH) begin
            m_owner = r; m_left = l + 1; plen[r] = l; obs[r] = 0;
          end
        end
      end
    end
    #1;
    if (auto_drop)
      for (int k = 0; k < 4; k++) if (done[k]) begin done[k] = 0; i_req[k] = 1'b0; end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] len0;
    logic [9:0] words;
    logic       full;
    logic [3:0] eg;
    logic       ee;
    logic [3:0] ea;
    logic       eb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int r = 0; r < 4; r++) begin pkt[r] = 0; wi[r] = 0; end
    auto_drop = 0;
    i_req = 4'd0; i_len = 16'd0; i_fifo_full = 1'b0; i_fifo_wr_words = 10'd0;
    prev_words = 0; rise_words = -1;
    raw_reset();

    //            rst   req   len  words full  gnt  en   ack  busy
    tbl[0]  = '{1'b1, 4'h0, 4'd3, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 4'd3, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'h1, 4'd3, 10'd0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1};
    tbl[3]  = '{1'b0, 4'h1, 4'd3, 10'd0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1};
    tbl[4]  = '{1'b0, 4'h1, 4'd3, 10'd0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1};
    tbl[5]  = '{1'b0, 4'h1, 4'd3, 10'd0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 4'd0, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 4'd0, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 4'd0, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'd0, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 4'd0, 10'd0, 1'b1, 4'h2, 1'b0, 4'h0, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 4'd0, 10'd0, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 4'd0, 10'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; i_req = tbl[i].req; i_len = {12'd0, tbl[i].len0};
      i_fifo_wr_words = tbl[i].words; i_fifo_full = tbl[i].full;
      drive_data();
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", i), o_gnt, tbl[i].eg);
      check($sformatf("tbl%0d_wr_en", i), o_fifo_wr_en, tbl[i].ee);
      check($sformatf("tbl%0d_ack", i), o_ack, tbl[i].ea);
      check($sformatf("tbl%0d_busy", i), o_busy, tbl[i].eb);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    $display("table vectors done: total=%0d", total);

    // All four request one-word packets continuously: strict rotation.
    i_req = 4'hF; i_len = 16'h0000; i_fifo_wr_words = 10'd0; i_fifo_full = 1'b0;
    raw_reset();
    dq.delete();
    for (int c = 0; c < 18; c++) run_cycle();
    check("rot_count", 64'(dq.size() >= 5), 64'd1);
    if (dq.size() >= 5) begin
      check("rot0", 64'(dq[0]), 64'd0);
      check("rot1", 64'(dq[1]), 64'd1);
      check("rot2", 64'(dq[2]), 64'd2);
      check("rot3", 64'(dq[3]), 64'd3);
      check("rot4", 64'(dq[4]), 64'd0);
    end
    $display("rotation sequence done: grants=%0d", dq.size());

    // Space check boundary: 16-word packet waits until occupancy reaches 496.
    auto_drop = 1;
    i_req = 4'h0; raw_reset();
    i_req = 4'h1; i_len = 16'h000F; dq.delete(); rise_words = -1;
    for (int w = 500; w >= 490; w--) begin
      i_fifo_wr_words = 10'(w);
      run_cycle();
    end
    i_fifo_wr_words = 10'd0;
    for (int c = 0; c < 24; c++) run_cycle();
    check("space_rise_words", 64'(rise_words), 64'd496);
    $display("space boundary done: grant after words=%0d", rise_words);

    // Full asserted for 3 cycles in the middle of a 10-word packet.
    i_req = 4'h0; raw_reset();
    i_req = 4'h4; i_len = 16'h0900;
    for (int c = 0; c < 4; c++) run_cycle();
    i_fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) run_cycle();
    i_fifo_full = 1'b0;
    for (int c = 0; c < 16; c++) run_cycle();
    $display("stall sequence done");

    // Reset on the second word of an 8-word packet.
    i_req = 4'h0; raw_reset();
    i_req = 4'h2; i_len = 16'h0070;
    run_cycle(); run_cycle();
    rst = 1'b1; run_cycle(); rst = 1'b0;
    dq.delete();
    i_req = 4'hA; i_len = 16'h3070;
    for (int c = 0; c < 30; c++) run_cycle();
    check("rst_regrant_count", 64'(dq.size() >= 1), 64'd1);
    if (dq.size() >= 1) check("rst_regrant_idx", 64'(dq[0]), 64'd1);
    $display("reset mid-packet done");

    // Randomized traffic.
    i_req = 4'h0; raw_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 4; r++)
        if (!i_req[r] && $urandom_range(3) == 0) begin
          i_req[r] = 1'b1;
          i_len[4*r +: 4] = 4'($urandom_range(15));
        end
      i_fifo_full = ($urandom_range(4) == 0);
      i_fifo_wr_words = ($urandom_range(3) == 0) ? 10'($urandom_range(512, 480))
                                                 : 10'($urandom_range(200));
      rst = ($urandom_range(299) == 0);
      run_cycle();
      rst = 1'b0;
    end
    $display("random traffic done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 512: capacity in words of the downstream FIFO, used in the space check.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles after each packet before the next arbitration, so the FIFO word count can settle.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_req, input, 4 bits: per-requester packet request, level, held until the last o_ack.
REQ-006 SHALL have port i_len, input, 16 bits: 4 bits per requester; value L means a packet of L+1 words (1..16).
REQ-007 SHALL have port i_data, input, 256 bits: 64 bits per requester; requester r uses [64r+63:64r]; the current word is valid while i_req[r]=1.
REQ-008 SHALL have port o_ack, output, 4 bits: per-requester word pop, high in the cycle a word of r is written.
REQ-009 SHALL have port o_gnt, output, 4 bits: one-hot owner of the FIFO write port, or all-zero.
REQ-010 SHALL have port o_fifo_wr_data, output, 64 bits: write data to the FIFO.
REQ-011 SHALL have port o_fifo_wr_en, output, 1 bit: FIFO write enable.
REQ-012 SHALL have port i_fifo_full, input, 1 bit: FIFO full flag.
REQ-013 SHALL have port i_fifo_wr_words, input, 10 bits: FIFO write-side occupancy, 0..512.
REQ-014 SHALL have port o_busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, XFER and GAP in a registered state machine.
REQ-016 In IDLE, SHALL select the first requester with i_req set, searching upward from rr_ptr with wrap 3->0.
REQ-017 SHALL grant the selected requester r only if i_fifo_wr_words + len(r) + 1 <= FIFO_DEPTH.
REQ-018 SHALL compute the space check at 11-bit width, with no overflow.
REQ-019 If the space check fails, SHALL grant nobody that cycle and SHALL re-evaluate the next cycle; SHALL NOT skip to the next requester, so no small packet overtakes the blocked one.
REQ-020 On grant, SHALL enter XFER, register o_gnt[r]=1, load word counter cnt=len(r) and latch the owner.
REQ-021 o_gnt SHALL rise one cycle after the IDLE cycle that granted.
REQ-022 In XFER, o_fifo_wr_en SHALL equal ~i_fifo_full (combinational).
REQ-023 In XFER, o_fifo_wr_data SHALL equal the owner's i_data slice.
REQ-024 In XFER, o_ack[owner] SHALL equal o_fifo_wr_en; all other o_ack bits SHALL be 0.
REQ-025 On each write with cnt>0, SHALL decrement cnt.
REQ-026 On a write with cnt=0 (last word), SHALL clear o_gnt next cycle, set rr_ptr=owner+1 mod 4 and enter GAP.
REQ-027 In XFER with i_fifo_full=1, SHALL hold all state and SHALL assert no write and no ack (stall).
REQ-028 A requester deasserting i_req mid-packet is a protocol violation; the block SHALL ignore it and continue writing.
REQ-029 GAP SHALL last exactly GAP_CYCLES cycles with no writes, then return to IDLE.
REQ-030 Outside XFER, o_fifo_wr_en and o_ack SHALL be 0.
REQ-031 Minimum packet time SHALL be 1 arbitration cycle + (len+1) write cycles + GAP_CYCLES.
REQ-032 Requests arriving during XFER or GAP SHALL wait; there is no preemption.

Reset
REQ-033 When rst=1 at a clock edge, the next state SHALL be: IDLE, rr_ptr=0, cnt=0, o_gnt=0, o_busy=0.
REQ-034 o_ack and o_fifo_wr_en SHALL be 0 from the first cycle of reset.
REQ-035 Reset during XFER SHALL abandon the packet; words already written stay in the FIFO, and the requester must re-request.
REQ-036 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-037 Reset, then i_req=0001 and i_len[3:0]=3 with the FIFO empty -> o_gnt=0001 one cycle later; 4 consecutive writes with o_ack[0]=1; then 2 idle cycles; rr_ptr=1.
REQ-038 i_req=1111 held, all lengths 0 -> one-word packets granted in order 0,1,2,3,0, each separated by 2 GAP cycles.
REQ-039 i_fifo_wr_words=500 and i_len(r)=15 -> no grant while the count is above 496; grant in the cycle after the count drops to 496.
REQ-040 i_fifo_full pulsed for 3 cycles mid-packet -> writes and acks pause 3 cycles; total words written equals len+1, in order, with no duplicates.
REQ-041 rst asserted on the 2nd word of an 8-word packet -> o_gnt=0 and o_fifo_wr_en=0 next cycle; the next grant goes to the lowest-numbered requesting index.
